// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit
// timing used by both the 8N1 transmitter and receiver.
package uart_pkg;

    // Clock cycles per bit; shared with the transmitter so both ends agree.
    localparam int CLKS_PER_BIT = 271;

    typedef enum logic [2:0] {
        s_IDLE         = 3'd0,
        s_RX_START_BIT = 3'd1,
        s_RX_DATA_BITS = 3'd2,
        s_RX_STOP_BIT  = 3'd3,
        s_CLEANUP      = 3'd4,
        s_BREAK        = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic 2-flop synchroniser for a single asynchronous input.
// Ports:
//   i_Clock  - destination clock
//   i_Rst_n  - asynchronous active-low reset; both flops load RST_VAL
//   i_Async  - asynchronous input
//   o_Sync   - synchronised output (2 cycles of latency)
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_Async;
            r_sync <= r_meta;
        end
    end

    assign o_Sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Synchronises the serial line, validates the start bit
// at mid-bit, samples each data bit at its centre (LSB first), and reports
// the byte with a one-cycle valid pulse or a one-cycle framing-error pulse.
// Ports:
//   i_Clock        - system clock
//   i_Rst_n        - asynchronous active-low reset
//   i_Rx_Serial    - asynchronous serial line, idle high
//   o_Rx_DV        - one-cycle pulse, o_Rx_Byte valid
//   o_Rx_Byte      - last good byte, held until the next one
//   o_Rx_Active    - high from start-bit detect until return to IDLE
//   o_Rx_Frame_Err - one-cycle pulse, stop bit sampled low
module uart_rx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    import uart_pkg::*;

    localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    logic       r_rx;

    rx_state_t  r_state,   n_state;
    logic [15:0] r_clk_cnt, n_clk_cnt;
    logic [2:0] r_bit_idx, n_bit_idx;
    logic [7:0] r_shift,   n_shift;
    logic [7:0] r_byte,    n_byte;
    logic       r_dv,      n_dv;
    logic       r_ferr,    n_ferr;
    logic       r_active,  n_active;

    // Line resets to idle-high so reset release cannot look like a start bit.
    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_Rx_Serial),
        .o_Sync  (r_rx)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state   <= s_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_dv      <= 1'b0;
            r_ferr    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= n_state;
            r_clk_cnt <= n_clk_cnt;
            r_bit_idx <= n_bit_idx;
            r_shift   <= n_shift;
            r_byte    <= n_byte;
            r_dv      <= n_dv;
            r_ferr    <= n_ferr;
            r_active  <= n_active;
        end
    end

    always_comb begin
        n_state   = r_state;
        n_clk_cnt = r_clk_cnt;
        n_bit_idx = r_bit_idx;
        n_shift   = r_shift;
        n_byte    = r_byte;
        n_dv      = 1'b0;
        n_ferr    = 1'b0;
        n_active  = r_active;

        case (r_state)
            s_IDLE: begin
                if (!r_rx) begin
                    n_state  = s_RX_START_BIT;
                    n_active = 1'b1;
                end
            end
            s_RX_START_BIT: begin
                if (r_clk_cnt == HALF_BIT) begin
                    // Still low at mid-bit: genuine start. High: glitch, drop it silently.
                    if (!r_rx) begin
                        n_state = s_RX_DATA_BITS;
                    end else begin
                        n_state  = s_IDLE;
                        n_active = 1'b0;
                    end
                end else begin
                    n_clk_cnt = r_clk_cnt + 16'd1;
                end
            end
            s_RX_DATA_BITS: begin
                if (r_clk_cnt == LAST_CLK) begin
                    n_shift[r_bit_idx] = r_rx;
                    n_clk_cnt          = '0;
                    if (r_bit_idx == 3'd7) n_state = s_RX_STOP_BIT;
                    else                   n_bit_idx = r_bit_idx + 3'd1;
                end else begin
                    n_clk_cnt = r_clk_cnt + 16'd1;
                end
            end
            s_RX_STOP_BIT: begin
                if (r_clk_cnt == LAST_CLK) begin
                    if (r_rx) begin
                        n_byte  = r_shift;
                        n_dv    = 1'b1;
                        n_state = s_CLEANUP;
                    end else begin
                        n_ferr  = 1'b1;
                        n_state = s_BREAK;
                    end
                end else begin
                    n_clk_cnt = r_clk_cnt + 16'd1;
                end
            end
            s_CLEANUP: begin
                n_state  = s_IDLE;
                n_active = 1'b0;
            end
            s_BREAK: begin
                // Hold here while the line stays low so a break yields one error only.
                if (r_rx) begin
                    n_state  = s_IDLE;
                    n_active = 1'b0;
                end
            end
            default: begin
                n_state  = s_IDLE;
                n_active = 1'b0;
            end
        endcase

        // Every state starts with fresh counters.
        if (n_state != r_state) begin
            n_clk_cnt = '0;
            n_bit_idx = '0;
        end
    end

    assign o_Rx_DV        = r_dv;
    assign o_Rx_Byte      = r_byte;
    assign o_Rx_Active    = r_active;
    assign o_Rx_Frame_Err = r_ferr;

endmodule
